// File: rtl/cla_serial_adder_ctrl.sv
// cla_serial_adder_ctrl: a WIDTH-bit adder built from one shared 4-bit CLA slice.
// Each cycle the slice adds one nibble, least-significant nibble first. The slice
// carry-out is registered and used as the carry-in for the next nibble.
// Optional feature macro: CLA_SERIAL_OVF_EN adds a registered two's-complement
// overflow output (ovf).
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit carry-lookahead slice (purely combinational)
module cla_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // lookahead carries, all derived from cin without rippling
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    counter;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last_pass;
`ifdef CLA_SERIAL_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  assign accept    = in_valid & in_ready;
  assign last_pass = (counter == LAST);

  cla_adder_4bit u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice sum enters the result register from the MSB side.
  // A 4-bit instance has no older nibbles to shift down.
  generate
    if (WIDTH > 4) begin : g_wide
      assign res_next = {slice_sum, res_sh[WIDTH-1:4]};
    end else begin : g_narrow
      assign res_next = slice_sum;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = ADD;  else state_next = IDLE;
      ADD:     if (last_pass) state_next = DONE; else state_next = ADD;
      DONE:    if (out_ready) state_next = IDLE; else state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Datapath: operand capture, per-nibble pass, and result load on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            counter <= '0;
`ifdef CLA_SERIAL_OVF_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
`endif
          end
        end
        ADD: begin
          res_sh <= res_next;
          carry  <= slice_cout;
          a_sh   <= a_sh >> 3'd4;
          b_sh   <= b_sh >> 3'd4;
          if (last_pass) begin
            sum  <= res_next;
            cout <= slice_cout;
`ifdef CLA_SERIAL_OVF_EN
            ovf  <= a_msb ^ b_msb ^ res_next[WIDTH-1] ^ slice_cout;
`endif
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DONE: begin
          counter <= counter;
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end
endmodule
